// File: rtl/riscv_dmem_ctrl.sv
// ============================================================================
// Module   : riscv_dmem_ctrl
// Brief    : Data memory with valid/ready handshake, programmable wait states,
//            RV32 load/store formatting and misaligned/range error flagging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_dmem_ctrl #(
  parameter int XLEN     = 32,
  parameter int ADDR_BIT = 12,
  parameter int LATENCY  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wr,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_busy
);

  localparam int         c_words    = 2 ** (ADDR_BIT - 2);
  localparam logic [3:0] c_cnt_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_wr;
  logic [ADDR_BIT-1:0] r_addr;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic [XLEN-1:0]     r_rdata;
  logic [31:0]         r_mem [c_words];

  logic                w_accept;
  logic                w_req_err;
  logic                w_commit;
  logic                w_we;
  logic                w_src_wr;
  logic [ADDR_BIT-1:0] w_src_addr;
  logic [1:0]          w_src_size;
  logic                w_src_unsigned;
  logic [31:0]         w_src_wdata;
  logic [ADDR_BIT-3:0] w_idx;
  logic [3:0]          w_be;
  logic [31:0]         w_wlane;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_load;

  assign w_accept    = i_req_valid && (r_state == S_IDLE);
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_comb begin
    w_req_err = 1'b0;
    case (i_req_size)
      2'b01:   w_req_err = i_req_addr[0];
      2'b10:   w_req_err = |i_req_addr[1:0];
      2'b11:   w_req_err = 1'b1;
      default: w_req_err = 1'b0;
    endcase
    if (|i_req_addr[XLEN-1:ADDR_BIT]) begin
      w_req_err = 1'b1;
    end
  end

  // A zero-latency access commits on the accept edge, before fields are registered.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_src_wr       = i_req_wr;
      w_src_addr     = i_req_addr[ADDR_BIT-1:0];
      w_src_size     = i_req_size;
      w_src_unsigned = i_req_unsigned;
      w_src_wdata    = i_req_wdata[31:0];
    end else begin
      w_src_wr       = r_wr;
      w_src_addr     = r_addr;
      w_src_size     = r_size;
      w_src_unsigned = r_unsigned;
      w_src_wdata    = r_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_cnt_init;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_idx = w_src_addr[ADDR_BIT-1:2];
  assign w_we  = w_commit && w_src_wr && !i_rst;

  always_comb begin
    w_be    = 4'b1111;
    w_wlane = w_src_wdata;
    case (w_src_size)
      2'b00: begin
        w_be    = 4'b0001 << w_src_addr[1:0];
        w_wlane = {4{w_src_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_src_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_src_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = w_src_wdata;
      end
    endcase
  end

  // Storage has no reset; its contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_half = w_src_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_src_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    case (w_src_size)
      2'b00:   w_load = {{(XLEN-8){~w_src_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(XLEN-16){~w_src_unsigned & w_half[15]}}, w_half};
      default: w_load = {{(XLEN-32){1'b0}}, w_word};
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr       <= i_req_wr;
        r_addr     <= i_req_addr[ADDR_BIT-1:0];
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_wdata    <= i_req_wdata[31:0];
        r_err      <= w_req_err;
        r_rdata    <= '0;
      end
      if (w_commit) begin
        r_rdata <= w_src_wr ? '0 : w_load;
      end
      if ((r_state == S_RESP) && i_rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_ctrl.sv
// ============================================================================
// Module   : tb_riscv_dmem_ctrl
// Brief    : Scoreboard bench for riscv_dmem_ctrl at LATENCY=2 and LATENCY=0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [1:0]  req_size  [2];
  logic        req_uns   [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.XLEN(32), .ADDR_BIT(12), .LATENCY(2)) dut (
    .i_clk(clk), .i_rst(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wr(req_wr[0]), .i_req_addr(req_addr[0]), .i_req_size(req_size[0]),
    .i_req_unsigned(req_uns[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]), .o_busy(busy[0])
  );

  riscv_dmem_ctrl #(.XLEN(32), .ADDR_BIT(12), .LATENCY(0)) dut0 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wr(req_wr[1]), .i_req_addr(req_addr[1]), .i_req_size(req_size[1]),
    .i_req_unsigned(req_uns[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]), .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_rdata"},     rsp_rdata[d],      32'd0);
    check({tag, "_err"},       32'(rsp_err[d]),   32'd0);
    check({tag, "_busy"},      32'(busy[d]),      32'd0);
  endtask

  task automatic drive(input int d, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    @(negedge clk);
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_size[d]  = size;
    req_uns[d]   = uns;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_size[d]  = 2'($urandom_range(0, 3));
  endtask

  // Latency counts edges from the accept edge (inclusive) to the one raising rsp_valid.
  task automatic access(input int d, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input string tag);
    exp_t e;
    int   lat;
    sb_q.push_back({exp_rd, exp_err});
    drive(d, wr, addr, size, uns, wdata);
    check({tag, "_busy"}, 32'(busy[d]), 32'd1);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata[d], e.rd);
    check({tag, "_err"}, 32'(rsp_err[d]), 32'(e.err));
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check({tag, "_done"}, {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = 32'd0;
      req_size[d] = 2'b10; req_uns[d] = 1'b0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_idle(0, "reset");
    check_idle(1, "reset0");

    // Basic store / load at LATENCY=2.
    access(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 3, "sw10");
    access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw10");

    // Load formatting.
    access(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h80FF7F01, 32'h0, 1'b0, 3, "sw20");
    access(0, 1'b0, 32'h23, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 3, "lb23");
    access(0, 1'b0, 32'h23, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 3, "lbu23");
    access(0, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 3, "lh22");
    access(0, 1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 32'h00007F01, 1'b0, 3, "lhu20");

    // Partial stores.
    access(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 3, "sw20b");
    access(0, 1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b0, 3, "sb21");
    access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0, 3, "lw20a");
    access(0, 1'b1, 32'h22, 2'b01, 1'b0, 32'hFFFF5566, 32'h0, 1'b0, 3, "sh22");
    access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h5566AA44, 1'b0, 3, "lw20b");

    // Error paths leave memory untouched.
    access(0, 1'b1, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3, "sw00");
    access(0, 1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lw02");
    access(0, 1'b1, 32'h01, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "sh01");
    access(0, 1'b1, 32'h20, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "size11");
    access(0, 1'b1, 32'h1020, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "swoor");
    access(0, 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lwoor");
    access(0, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3, "lw00");
    access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h5566AA44, 1'b0, 3, "lw20c");

    // Back-pressure: response held, competing request ignored.
    drive(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_valid0", 32'(rsp_valid[0]), 32'd1);
    req_wr[0] = 1'b1; req_addr[0] = 32'h10; req_size[0] = 2'b10; req_wdata[0] = 32'h0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("bp_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    check_idle(0, "bp_end");
    access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, "bp_lw10");

    // Reset in WAIT aborts the store.
    access(0, 1'b1, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3, "sw30z");
    drive(0, 1'b1, 32'h30, 2'b10, 1'b0, 32'h12345678);
    @(posedge clk);
    #1;
    check("abort_wait_busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    check_idle(0, "abort_rst");
    @(negedge clk);
    rst[0] = 1'b0;
    access(0, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3, "abort_lw30");

    // LATENCY=0: accept commits, reset in RESP drops only the response.
    access(1, 1'b1, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1, "l0_sw30z");
    access(1, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1, "l0_lw30z");
    drive(1, 1'b1, 32'h30, 2'b10, 1'b0, 32'h12345678);
    check("l0_resp_valid", 32'(rsp_valid[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    check_idle(1, "l0_rst");
    @(negedge clk);
    rst[1] = 1'b0;
    access(1, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 1, "l0_lw30");
    access(1, 1'b0, 32'h31, 2'b00, 1'b1, 32'h0, 32'h00000056, 1'b0, 1, "l0_lbu31");
    access(1, 1'b0, 32'h31, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1, "l0_lh31");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
